// File: rtl/calc_operand_sequencer.sv
// calc_operand_sequencer
//   Sits between a host operand stream and the calculator datapath. It accepts
//   one operand pair, holds it on op_a/op_b, and watches the controller's
//   op_code together with the ALU result. It keeps the latest result seen for
//   each op_code (0..3). When all four codes have been seen, or the run times
//   out, it emits the four results as one packed record.
//
// Handshake rule (both streams): a transfer happens on a rising clk edge
//   where valid and ready are both 1. A producer holds valid and data stable
//   until that transfer. Once valid is raised, it only drops through a
//   transfer or through reset.
//
// Ports
//   clk, reset          clock; synchronous active-high reset
//   in_valid/in_ready   operand pair stream (in_a, in_b)
//   op_a, op_b          registered operands driven to the calculator
//   op_code, result     controller op_code and calculator result, observed
//   out_valid/out_ready record stream
//   out_results         slot k = bits [k*WIDTH +: WIDTH]
//   out_timeout         record closed by timeout; unseen slots read 0
//
// The FSM state is held in `state` (type state_t) for checkers to bind to.
module calc_operand_sequencer #(
  parameter int WIDTH   = 8,
  parameter int TIMEOUT = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_a,
  input  logic [WIDTH-1:0]   in_b,
  output logic [WIDTH-1:0]   op_a,
  output logic [WIDTH-1:0]   op_b,
  input  logic [1:0]         op_code,
  input  logic [WIDTH-1:0]   result,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [4*WIDTH-1:0] out_results,
  output logic               out_timeout
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  state_t                  state;
  logic [3:0][WIDTH-1:0]   slots;
  logic [3:0]              seen;
  logic [7:0]              cnt;
  logic [3:0]              code_hot;
  logic [3:0]              seen_next;

  // seen_next includes the code captured this cycle. Completion can then be
  // detected on the same edge as the last capture.
  always_comb begin
    code_hot  = 4'b0001 << op_code;
    seen_next = seen | code_hot;
  end

  assign out_results = slots;

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      op_a        <= '0;
      op_b        <= '0;
      slots       <= '0;
      seen        <= '0;
      cnt         <= '0;
      in_ready    <= 1'b1;
      out_valid   <= 1'b0;
      out_timeout <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            op_a        <= in_a;
            op_b        <= in_b;
            slots       <= '0;
            seen        <= '0;
            cnt         <= '0;
            out_timeout <= 1'b0;
            in_ready    <= 1'b0;
            state       <= RUN;
          end
        end
        RUN: begin
          // A repeated op_code overwrites its slot, so the latest value wins.
          slots[op_code] <= result;
          seen           <= seen_next;
          cnt            <= cnt + 8'd1;
          // Completion is checked first, so it wins over timeout on the final cycle.
          if (seen_next == 4'b1111) begin
            out_valid   <= 1'b1;
            out_timeout <= 1'b0;
            state       <= DONE;
          end else if (cnt == CNT_LAST) begin
            out_valid   <= 1'b1;
            out_timeout <= 1'b1;
            state       <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          state     <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_calc_operand_sequencer.sv
// Testbench for calc_operand_sequencer (WIDTH=8, TIMEOUT=16).
// Inputs change 1 time unit after each rising edge. Outputs are checked
// at that same point.
module tb_calc_operand_sequencer;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_a;
  logic [7:0]  in_b;
  logic [7:0]  op_a;
  logic [7:0]  op_b;
  logic [1:0]  op_code;
  logic [7:0]  result;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_results;
  logic        out_timeout;

  int tests;
  int fails;

  calc_operand_sequencer #(.WIDTH(8), .TIMEOUT(16)) dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_a        (in_a),
    .in_b        (in_b),
    .op_a        (op_a),
    .op_b        (op_b),
    .op_code     (op_code),
    .result      (result),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_results (out_results),
    .out_timeout (out_timeout)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- drivers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer a pair and wait, bounded, until it is accepted. With hold=1,
  // in_valid stays high after the accept.
  task automatic send_pair(input logic [7:0] a, input logic [7:0] b, input bit hold);
    bit ok;
    ok = 1'b0;
    in_a     = a;
    in_b     = b;
    in_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (in_ready) begin
        tick();
        ok = 1'b1;
        break;
      end
      tick();
    end
    if (!hold) in_valid = 1'b0;
    tests++;
    if (!ok) begin
      fails++;
      $display("FAIL send_pair_accept: accepted=%0b required=1", ok);
    end
  endtask

  task automatic capture(input logic [1:0] c, input logic [7:0] r);
    op_code = c;
    result  = r;
    tick();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    do_reset();
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready: got %0b exp 1", in_ready); end
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid: got %0b exp 0", out_valid); end
    tests++; if (out_timeout !== 1'b0) begin fails++; $display("FAIL reset_out_timeout: got %0b exp 0", out_timeout); end
    tests++; if (op_a !== 8'h00 || op_b !== 8'h00) begin fails++; $display("FAIL reset_ops: got %h/%h exp 00/00", op_a, op_b); end
    tests++; if (out_results !== 32'h0) begin fails++; $display("FAIL reset_results: got %h exp 00000000", out_results); end
  endtask

  task automatic test_reset_mid_run();
    send_pair(8'hC3, 8'h3C, 1'b0);
    tests++; if (op_a !== 8'hC3 || in_ready !== 1'b0) begin fails++; $display("FAIL midrun_accept: op_a=%h in_ready=%0b exp C3/0", op_a, in_ready); end
    capture(2'd0, 8'h77);
    op_code = 2'd1;
    result  = 8'h66;
    do_reset();
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL midrun_out_valid: got %0b exp 0", out_valid); end
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL midrun_in_ready: got %0b exp 1", in_ready); end
    tests++; if (op_a !== 8'h00 || op_b !== 8'h00) begin fails++; $display("FAIL midrun_ops: got %h/%h exp 00/00", op_a, op_b); end
  endtask

  task automatic test_in_order();
    out_ready = 1'b1;
    send_pair(8'h01, 8'h02, 1'b0);
    capture(2'd0, 8'h11);
    capture(2'd1, 8'h22);
    capture(2'd2, 8'h33);
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL inorder_early_valid: got %0b exp 0", out_valid); end
    capture(2'd3, 8'h44);
    tests++; if (out_valid !== 1'b1) begin fails++; $display("FAIL inorder_valid: got %0b exp 1", out_valid); end
    tests++; if (out_results !== 32'h44332211) begin fails++; $display("FAIL inorder_results: got %h exp 44332211", out_results); end
    tests++; if (out_timeout !== 1'b0) begin fails++; $display("FAIL inorder_timeout: got %0b exp 0", out_timeout); end
    tick();
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL inorder_one_cycle: got %0b exp 0", out_valid); end
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL inorder_back_idle: got %0b exp 1", in_ready); end
  endtask

  task automatic test_repeat_overwrite();
    send_pair(8'h05, 8'h06, 1'b0);
    capture(2'd2, 8'd5);
    capture(2'd2, 8'd6);
    capture(2'd0, 8'd7);
    capture(2'd3, 8'd8);
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL repeat_early_valid: got %0b exp 0", out_valid); end
    capture(2'd1, 8'd9);
    tests++; if (out_valid !== 1'b1) begin fails++; $display("FAIL repeat_valid: got %0b exp 1", out_valid); end
    tests++; if (out_results !== 32'h08060907) begin fails++; $display("FAIL repeat_results: got %h exp 08060907", out_results); end
    tick();
  endtask

  task automatic test_timeout();
    send_pair(8'hAA, 8'hBB, 1'b0);
    for (int i = 0; i < 15; i++) capture(2'd1, 8'hAB);
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL timeout_early_valid: got %0b exp 0", out_valid); end
    capture(2'd1, 8'hAB);
    tests++; if (out_valid !== 1'b1) begin fails++; $display("FAIL timeout_valid: got %0b exp 1", out_valid); end
    tests++; if (out_timeout !== 1'b1) begin fails++; $display("FAIL timeout_flag: got %0b exp 1", out_timeout); end
    tests++; if (out_results !== 32'h0000AB00) begin fails++; $display("FAIL timeout_results: got %h exp 0000AB00", out_results); end
    tick();
  endtask

  // The last of 16 RUN cycles completes the set: completion must win over timeout.
  task automatic test_complete_at_limit();
    send_pair(8'h10, 8'h20, 1'b0);
    for (int i = 0; i < 13; i++) capture(2'd0, 8'(i));
    capture(2'd1, 8'hA1);
    capture(2'd2, 8'hA2);
    capture(2'd3, 8'hA3);
    tests++; if (out_valid !== 1'b1) begin fails++; $display("FAIL limit_valid: got %0b exp 1", out_valid); end
    tests++; if (out_timeout !== 1'b0) begin fails++; $display("FAIL limit_timeout: got %0b exp 0", out_timeout); end
    tests++; if (out_results !== 32'hA3A2A10C) begin fails++; $display("FAIL limit_results: got %h exp A3A2A10C", out_results); end
    tick();
  endtask

  task automatic test_backpressure();
    int bad_valid, bad_res, bad_op, bad_rdy;
    bad_valid = 0; bad_res = 0; bad_op = 0; bad_rdy = 0;
    out_ready = 1'b0;
    send_pair(8'h12, 8'h34, 1'b0);
    capture(2'd0, 8'h01);
    capture(2'd1, 8'h02);
    capture(2'd2, 8'h03);
    capture(2'd3, 8'h04);
    op_code  = 2'd0;
    result   = 8'hEE;
    in_a     = 8'h5A;
    in_b     = 8'hA5;
    in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (out_valid !== 1'b1) bad_valid++;
      if (out_results !== 32'h04030201) bad_res++;
      if (op_a !== 8'h12) bad_op++;
      if (in_ready !== 1'b0) bad_rdy++;
      tick();
    end
    tests++; if (bad_valid != 0) begin fails++; $display("FAIL bp_valid_stable: %0d cycles wrong, exp 0", bad_valid); end
    tests++; if (bad_res != 0) begin fails++; $display("FAIL bp_results_stable: %0d cycles wrong (now %h) exp 0", bad_res, out_results); end
    tests++; if (bad_op != 0) begin fails++; $display("FAIL bp_op_a_held: %0d cycles wrong (now %h) exp 0", bad_op, op_a); end
    tests++; if (bad_rdy != 0) begin fails++; $display("FAIL bp_in_ready_low: %0d cycles wrong, exp 0", bad_rdy); end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    tests++; if (out_valid !== 1'b0 || op_a !== 8'h12) begin fails++; $display("FAIL bp_release: valid=%0b op_a=%h exp 0/12", out_valid, op_a); end
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b1;
    send_pair(8'd3, 8'd4, 1'b1);
    in_a = 8'd9;
    in_b = 8'd1;
    tests++; if (op_a !== 8'd3 || op_b !== 8'd4) begin fails++; $display("FAIL b2b_first: got %h/%h exp 03/04", op_a, op_b); end
    capture(2'd0, 8'h01);
    capture(2'd1, 8'h02);
    capture(2'd2, 8'h03);
    capture(2'd3, 8'h04);
    tests++; if (out_valid !== 1'b1) begin fails++; $display("FAIL b2b_done: got %0b exp 1", out_valid); end
    tick();
    tests++; if (in_ready !== 1'b1 || op_a !== 8'd3) begin fails++; $display("FAIL b2b_idle: in_ready=%0b op_a=%h exp 1/03", in_ready, op_a); end
    tick();
    in_valid = 1'b0;
    tests++; if (op_a !== 8'd9 || op_b !== 8'd1) begin fails++; $display("FAIL b2b_second: got %h/%h exp 09/01", op_a, op_b); end
    tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL b2b_second_ready: got %0b exp 0", in_ready); end
    do_reset();
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    tests     = 0;
    fails     = 0;
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    op_code   = '0;
    result    = '0;
    out_ready = 1'b1;
    tick();
    test_reset();
    test_reset_mid_run();
    test_in_order();
    test_repeat_overwrite();
    test_timeout();
    test_complete_at_limit();
    test_backpressure();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
